// File: rtl/command_deframer_if.sv
// Byte-stream handshake bundle between a host link and the command deframer.
interface command_deframer_if;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic       rx_ready_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;

    // Deframer side
    modport slave (
        input  rx_data_i,
        input  rx_valid_i,
        input  tx_ready_i,
        output rx_ready_o,
        output tx_data_o,
        output tx_valid_o
    );

    // Host side
    modport master (
        output rx_data_i,
        output rx_valid_i,
        output tx_ready_i,
        input  rx_ready_o,
        input  tx_data_o,
        input  tx_valid_o
    );
endinterface

// File: rtl/command_deframer.sv
// Command deframer: turns an inbound byte stream into single-cycle core
// write/read commands and streams read results back out, MSB first.
module command_deframer #(
    parameter int unsigned RESULT_LATENCY = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  WRITE_OPCODE   = 8'h01,
    parameter logic [7:0]  READ_OPCODE    = 8'h02
) (
    input  logic                clk_i,
    input  logic                rst_i,
    command_deframer_if.slave   bus,
    output logic [7:0]          instruction_o,
    output logic [23:0]         address_o,
    output logic [31:0]         value_o,
    input  logic [31:0]         result_i,
    output logic                error_o,
    output logic                busy_o
);

    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned LAT_W = 4;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        RX_ADDR     = 3'd1,
        RX_VALUE    = 3'd2,
        ISSUE       = 3'd3,
        WAIT_RESULT = 3'd4,
        TX_RESULT   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [23:0]       addr_sh_q, addr_sh_d;
    logic [23:0]       val_sh_q, val_sh_d;
    logic [31:0]       res_sh_q, res_sh_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [TO_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [7:0]        instr_q, instr_d;
    logic [23:0]       address_q, address_d;
    logic [31:0]       value_q, value_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              rx_ready_q, rx_ready_d;
    logic              error_q, error_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic [7:0]        rx_byte;
    logic              timeout_hit;

    assign rx_byte     = bus.rx_data_i;
    assign accept      = bus.rx_valid_i && rx_ready_q;
    assign timeout_hit = (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        addr_sh_d  = addr_sh_q;
        val_sh_d   = val_sh_q;
        res_sh_d   = res_sh_q;
        byte_cnt_d = byte_cnt_q;
        idle_cnt_d = idle_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        instr_d    = 8'h00;
        address_d  = address_q;
        value_d    = value_q;
        tx_data_d  = tx_data_q;
        error_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (rx_byte == WRITE_OPCODE || rx_byte == READ_OPCODE) begin
                        opcode_d   = rx_byte;
                        byte_cnt_d = 2'd0;
                        idle_cnt_d = '0;
                        state_d    = RX_ADDR;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end

            RX_ADDR: begin
                if (accept) begin
                    idle_cnt_d = '0;
                    addr_sh_d  = {addr_sh_q[15:0], rx_byte};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd2) begin
                        byte_cnt_d = 2'd0;
                        if (opcode_q == WRITE_OPCODE) begin
                            state_d = RX_VALUE;
                        end else begin
                            // Read: value_o is deliberately left untouched.
                            address_d = {addr_sh_q[15:0], rx_byte};
                            instr_d   = opcode_q;
                            state_d   = ISSUE;
                        end
                    end
                end else if (timeout_hit) begin
                    idle_cnt_d = '0;
                    error_d    = 1'b1;
                    state_d    = IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + TO_W'(1);
                end
            end

            RX_VALUE: begin
                if (accept) begin
                    idle_cnt_d = '0;
                    val_sh_d   = {val_sh_q[15:0], rx_byte};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = 2'd0;
                        address_d  = addr_sh_q;
                        value_d    = {val_sh_q, rx_byte};
                        instr_d    = opcode_q;
                        state_d    = ISSUE;
                    end
                end else if (timeout_hit) begin
                    idle_cnt_d = '0;
                    error_d    = 1'b1;
                    state_d    = IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + TO_W'(1);
                end
            end

            ISSUE: begin
                // The cycle after ISSUE is issue+1 on the latency count.
                lat_cnt_d = LAT_W'(1);
                state_d   = (opcode_q == WRITE_OPCODE) ? IDLE : WAIT_RESULT;
            end

            WAIT_RESULT: begin
                if (lat_cnt_q == LAT_W'(RESULT_LATENCY)) begin
                    tx_data_d  = result_i[31:24];
                    res_sh_d   = {result_i[23:0], 8'h00};
                    byte_cnt_d = 2'd0;
                    state_d    = TX_RESULT;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end

            TX_RESULT: begin
                if (tx_valid_q && bus.tx_ready_i) begin
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = 2'd0;
                        state_d    = IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        tx_data_d  = res_sh_q[31:24];
                        res_sh_d   = {res_sh_q[23:0], 8'h00};
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        rx_ready_d = (state_d == IDLE) || (state_d == RX_ADDR) || (state_d == RX_VALUE);
        busy_d     = (state_d != IDLE);
        tx_valid_d = (state_d == TX_RESULT);
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            opcode_q   <= 8'h00;
            addr_sh_q  <= '0;
            val_sh_q   <= '0;
            res_sh_q   <= '0;
            byte_cnt_q <= 2'd0;
            idle_cnt_q <= '0;
            lat_cnt_q  <= '0;
            instr_q    <= 8'h00;
            address_q  <= '0;
            value_q    <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            rx_ready_q <= 1'b1;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            addr_sh_q  <= addr_sh_d;
            val_sh_q   <= val_sh_d;
            res_sh_q   <= res_sh_d;
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            instr_q    <= instr_d;
            address_q  <= address_d;
            value_q    <= value_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            rx_ready_q <= rx_ready_d;
            error_q    <= error_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.rx_ready_o = rx_ready_q;
    assign bus.tx_data_o  = tx_data_q;
    assign bus.tx_valid_o = tx_valid_q;
    assign instruction_o  = instr_q;
    assign address_o      = address_q;
    assign value_o        = value_q;
    assign error_o        = error_q;
    assign busy_o         = busy_q;

endmodule
